cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Control FSM for the 2-way set-associative, 8-set, write-back cache built from `given_array` metadata/data arrays. It sits directly upstream of those arrays: it consumes their status (hit, valid, dirty, LRU) for the set selected by the CPU address and produces every array `load` strobe, write-data mux select and physical-memory request. It handles the CPU handshake (`mem_read`/`mem_write`/`mem_resp`) and the line-granular memory handshake (`pmem_read`/`pmem_write`/`pmem_resp`).

## Interface
- `s_offset`, 5, line offset bits (32-byte lines)
- `s_index`, 3, set index bits; fixed by the 3-bit array index
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `mem_read`, `mem_write`  in  1  CPU request, held until `mem_resp`; never both high
- `mem_resp`  out  1  single-cycle completion pulse
- `hit`  in  2  per-way tag match AND valid, from datapath comparators
- `valid`, `dirty`  in  2  per-way array outputs for current index
- `lru`  in  1  LRU array output; value = way to evict
- `load_data`, `load_tag`, `load_valid`, `load_dirty`  out  2  per-way array write strobes
- `dirty_in`  out  1  value written to dirty array
- `load_lru`, `lru_in`  out  1 / 1  LRU update strobe and value
- `data_sel`  out  1  0 = merge CPU write data, 1 = line from memory
- `addr_sel`  out  1  0 = `{cpu tag, index, 0}`, 1 = `{victim tag, index, 0}`
- `pmem_read`, `pmem_write`  out  1  memory request, held until `pmem_resp`
- `pmem_resp`  in  1  memory completion pulse

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE.
- IDLE: all strobes 0. `mem_read|mem_write` -> CHECK next cycle.
- CHECK, hit on way w: `mem_resp`=1; `load_lru`=1, `lru_in`=~w. Write hit additionally: `load_data[w]`=1, `data_sel`=0, `load_dirty[w]`=1, `dirty_in`=1. -> IDLE.
- CHECK, miss: victim v = `lru`. `valid[v]&dirty[v]` -> WRITEBACK, else -> ALLOCATE. No strobes, `mem_resp`=0.
- WRITEBACK: `pmem_write`=1, `addr_sel`=1. On `pmem_resp` -> ALLOCATE.
- ALLOCATE: `pmem_read`=1, `addr_sel`=0. On `pmem_resp`: `load_data[v]`, `load_tag[v]`, `load_valid[v]`, `load_dirty[v]` = 1, `data_sel`=1, `dirty_in`=0; -> CHECK (re-check hits).
- Victim v registered on CHECK->miss exit; stable through WRITEBACK/ALLOCATE even though `lru` is unchanged.
- `hit` = 2'b11 is illegal; way 0 takes priority.
- Default outputs 0 in every state.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, v=0; all outputs 0 combinationally from IDLE. Reset mid-WRITEBACK/ALLOCATE drops `pmem_*` the following cycle; a `pmem_resp` arriving in or after the reset cycle is ignored.
- Outputs are Moore on state plus combinational on `hit`/`pmem_resp` (array reads are combinational with write bypass, so status is valid in the cycle of the request).
- Hit latency: request seen in IDLE at cycle 0, `mem_resp` cycle 1.
- Clean miss: CHECK, ALLOCATE (N cycles until `pmem_resp`), CHECK hit: `mem_resp` at cycle 1+N+1.
- Dirty miss adds WRITEBACK duration before ALLOCATE.
- `pmem_resp` outside WRITEBACK/ALLOCATE ignored.
- CPU may assert a new request in the cycle after `mem_resp`; IDLE accepts it immediately.

## Structure
- `cache_ctrl_pkg`: state enum, `s_offset`/`s_index`/tag-width constants, `data_sel`/`addr_sel` encodings; shared with cache datapath.
- Single module; no sub-module needed (arrays instantiated by the datapath, not here).

## Test plan
- Reset: `rst_n`=0 two cycles with `mem_read`=1 -> all outputs 0, state IDLE; release -> CHECK next cycle.
- Read hit: `hit`=2'b10 -> `mem_resp` cycle 1, `load_lru`=1, `lru_in`=0, no `load_data`.
- Write hit: `hit`=2'b01, `mem_write`=1 -> `load_data`=2'b01, `load_dirty`=2'b01, `dirty_in`=1, `data_sel`=0, `lru_in`=1.
- Clean miss: `hit`=0, `lru`=1, `valid`=2'b10, `dirty`=0, `pmem_resp` after 5 cycles -> `pmem_read` 5 cycles, load strobes 2'b10 with `data_sel`=1, `dirty_in`=0; then hit -> `mem_resp` at cycle 7.
- Dirty miss: `lru`=0, `valid`=`dirty`=2'b01 -> `pmem_write` with `addr_sel`=1 until `pmem_resp`, then `pmem_read`, then `mem_resp`.
- Reset during ALLOCATE with `pmem_resp` same cycle -> no array strobes, `pmem_read`=0 next cycle, no `mem_resp`.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way, 8-set, write-back cache controller and
// its datapath: address field widths, FSM state encoding and mux encodings.
package cache_ctrl_pkg;

    // Address split for a 32-bit byte address with 32-byte lines and 8 sets.
    localparam int ADDR_W   = 32;
    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = ADDR_W - S_OFFSET - S_INDEX;
    localparam int NUM_WAYS = 2;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    // Data array write-data mux: merge CPU store data, or take a whole line from memory.
    localparam logic DATA_SEL_CPU = 1'b0;
    localparam logic DATA_SEL_MEM = 1'b1;

    // Physical-memory address mux: CPU tag for fills, victim tag for write-backs.
    localparam logic ADDR_SEL_CPU    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;

    // One-hot per-way strobe for way w.
    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Way that hit; way 0 wins if both comparators ever fire together.
    function automatic logic hit_way(input logic [NUM_WAYS-1:0] hit);
        return hit[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Control FSM for the 2-way set-associative write-back cache. Reads per-set
// status from the metadata arrays and drives every array write strobe, the
// data/address muxes, the CPU completion pulse and the line-sized memory
// requests. Victim way is latched on a miss so it stays fixed while the
// write-back and fill complete.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,

    // CPU side
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,

    // Array status for the set selected by the CPU address
    input  logic [1:0] hit,
    input  logic [1:0] valid,
    input  logic [1:0] dirty,
    input  logic       lru,

    // Array write controls
    output logic [1:0] load_data,
    output logic [1:0] load_tag,
    output logic [1:0] load_valid,
    output logic [1:0] load_dirty,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in,
    output logic       data_sel,
    output logic       addr_sel,

    // Physical memory side
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp
);

    state_t state;
    state_t state_next;

    logic   victim;
    logic   victim_capture;

    logic   hit_any;
    logic   hit_w;
    logic   victim_dirty;

    assign hit_any      = |hit;
    assign hit_w        = hit_way(hit);
    assign victim_dirty = valid[lru] & dirty[lru];

    // State register; synchronous active-low reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Victim way latched when CHECK resolves to a miss, held through write-back and fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            victim <= 1'b0;
        end else if (victim_capture) begin
            victim <= lru;
        end
    end

    // Next-state and output decode; event-driven strobes are suppressed while
    // reset is asserted so a late hit or pmem_resp cannot touch the arrays.
    always_comb begin
        state_next     = state;
        victim_capture = 1'b0;

        mem_resp   = 1'b0;
        load_data  = 2'b00;
        load_tag   = 2'b00;
        load_valid = 2'b00;
        load_dirty = 2'b00;
        dirty_in   = 1'b0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        data_sel   = DATA_SEL_CPU;
        addr_sel   = ADDR_SEL_CPU;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    state_next = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (hit_any) begin
                    state_next = ST_IDLE;
                    if (rst_n) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit_w;
                        if (mem_write) begin
                            load_data  = way_onehot(hit_w);
                            load_dirty = way_onehot(hit_w);
                            dirty_in   = 1'b1;
                            data_sel   = DATA_SEL_CPU;
                        end
                    end
                end else begin
                    victim_capture = 1'b1;
                    state_next     = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end

            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = ADDR_SEL_VICTIM;
                if (pmem_resp) begin
                    state_next = ST_ALLOCATE;
                end
            end

            ST_ALLOCATE: begin
                pmem_read = 1'b1;
                addr_sel  = ADDR_SEL_CPU;
                if (pmem_resp) begin
                    state_next = ST_CHECK;
                    if (rst_n) begin
                        load_data  = way_onehot(victim);
                        load_tag   = way_onehot(victim);
                        load_valid = way_onehot(victim);
                        load_dirty = way_onehot(victim);
                        dirty_in   = 1'b0;
                        data_sel   = DATA_SEL_MEM;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed steps followed by randomized CPU traffic.
// A small cache model (valid/dirty/tag/LRU per set) supplies array status and
// predicts, transaction by transaction, the cycle-by-cycle controller outputs.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write, mem_resp;
    logic [1:0] hit, valid, dirty;
    logic       lru;
    logic [1:0] load_data, load_tag, load_valid, load_dirty;
    logic       dirty_in, load_lru, lru_in, data_sel, addr_sel;
    logic       pmem_read, pmem_write, pmem_resp;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural cache model: what the metadata arrays hold.
    logic [1:0] m_valid [8];
    logic [1:0] m_dirty [8];
    logic       m_lru   [8];
    logic [1:0] m_tag   [8][2];

    cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .lru        (lru),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .dirty_in   (dirty_in),
        .load_lru   (load_lru),
        .lru_in     (lru_in),
        .data_sel   (data_sel),
        .addr_sel   (addr_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Pack an expected output set in the same order as the observed vector.
    function automatic logic [15:0] ev(input logic mr, input logic [1:0] ld, input logic [1:0] lt,
                                       input logic [1:0] lv, input logic [1:0] ldt, input logic di,
                                       input logic ll, input logic li, input logic ds, input logic as_,
                                       input logic pr, input logic pw);
        return {mr, ld, lt, lv, ldt, di, ll, li, ds, as_, pr, pw};
    endfunction

    function automatic logic [1:0] model_hit(input int s, input logic [1:0] tg);
        logic [1:0] h;
        for (int w = 0; w < 2; w++) h[w] = m_valid[s][w] && (m_tag[s][w] == tg);
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
               load_lru, lru_in, data_sel, addr_sel, pmem_read, pmem_write};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_status(input int s, input logic [1:0] tg);
        hit   = model_hit(s, tg);
        valid = m_valid[s];
        dirty = m_dirty[s];
        lru   = m_lru[s];
    endtask

    // One CPU transaction from IDLE to mem_resp, with memory latencies
    // n_wb / n_al (0 = random). Updates the model as the cache would.
    task automatic do_txn(input logic wr, input int s, input logic [1:0] tg,
                          input int n_wb, input int n_al);
        logic [1:0] mh;
        logic       w, v, last;
        int         nw, na;
        bit         done;
        done      = 0;
        mem_read  = ~wr;
        mem_write = wr;
        drive_status(s, tg);
        pmem_resp = 1'($urandom_range(0, 1));
        #1 chk("idle_accept", 16'h0000);
        tick();
        for (int pass = 0; pass < 2 && !done; pass++) begin
            drive_status(s, tg);
            pmem_resp = 1'($urandom_range(0, 1));
            mh = model_hit(s, tg);
            #1;
            if (mh != 2'b00) begin
                w = mh[0] ? 1'b0 : 1'b1;
                chk(wr ? "write_hit" : "read_hit",
                    ev(1'b1, wr ? oh(w) : 2'b00, 2'b00, 2'b00, wr ? oh(w) : 2'b00, wr,
                       1'b1, ~w, 1'b0, 1'b0, 1'b0, 1'b0));
                tick();
                mem_read  = 1'b0;
                mem_write = 1'b0;
                m_lru[s]  = ~w;
                if (wr) m_dirty[s][w] = 1'b1;
                done = 1;
            end else begin
                chk("miss_check", 16'h0000);
                v = m_lru[s];
                tick();
                if (m_valid[s][v] && m_dirty[s][v]) begin
                    nw = (n_wb > 0) ? n_wb : $urandom_range(1, 5);
                    for (int k = 0; k < nw; k++) begin
                        pmem_resp = (k == nw - 1);
                        hit = 2'($urandom_range(0, 3));
                        lru = 1'($urandom_range(0, 1));
                        #1 chk("writeback", ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
                                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                        tick();
                    end
                end
                na = (n_al > 0) ? n_al : $urandom_range(1, 5);
                for (int k = 0; k < na; k++) begin
                    last = (k == na - 1);
                    pmem_resp = last;
                    hit = 2'($urandom_range(0, 3));
                    lru = 1'($urandom_range(0, 1));
                    #1 chk("allocate", ev(1'b0, last ? oh(v) : 2'b00, last ? oh(v) : 2'b00,
                                          last ? oh(v) : 2'b00, last ? oh(v) : 2'b00, 1'b0,
                                          1'b0, 1'b0, last, 1'b0, 1'b1, 1'b0));
                    tick();
                end
                m_valid[s][v]  = 1'b1;
                m_dirty[s][v]  = 1'b0;
                m_tag[s][v]    = tg;
            end
        end
        pmem_resp = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 2'b00;
            m_dirty[s] = 2'b00;
            m_lru[s]   = 1'b0;
            m_tag[s][0] = 2'd0;
            m_tag[s][1] = 2'd0;
        end

        // Reset held two cycles with a pending read.
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        hit = 2'b10; valid = 2'b11; dirty = 2'b00; lru = 1'b0; pmem_resp = 1'b0;
        tick(); chk("reset_c1", 16'h0000);
        tick(); chk("reset_c2", 16'h0000);
        rst_n = 1'b1;
        #1 chk("reset_release_idle", 16'h0000);
        tick();
        // Read hit on way 1 right after release.
        #1 chk("read_hit_w1", ev(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        mem_read = 1'b0;
        #1 chk("idle_after_hit", 16'h0000);
        tick();

        // Both ways report a hit: way 0 wins.
        mem_write = 1'b1; hit = 2'b11;
        #1 chk("dual_hit_idle", 16'h0000);
        tick();
        #1 chk("dual_hit_w0", ev(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        mem_write = 1'b0; hit = 2'b00;

        // Write hit on way 0 via the model.
        m_valid[2] = 2'b01; m_tag[2][0] = 2'd3; m_lru[2] = 1'b0;
        do_txn(1'b1, 2, 2'd3, 0, 0);

        // Clean miss: lru=1, way 1 valid and clean, fill takes 5 cycles.
        m_valid[0] = 2'b10; m_dirty[0] = 2'b00; m_lru[0] = 1'b1;
        m_tag[0][1] = 2'd1;
        do_txn(1'b0, 0, 2'd2, 0, 5);

        // Dirty miss: lru=0, way 0 valid and dirty.
        m_valid[1] = 2'b01; m_dirty[1] = 2'b01; m_lru[1] = 1'b0;
        m_tag[1][0] = 2'd0;
        do_txn(1'b1, 1, 2'd1, 3, 2);

        // Reset during ALLOCATE with pmem_resp in the same cycle.
        m_valid[3] = 2'b00; m_dirty[3] = 2'b00; m_lru[3] = 1'b0;
        mem_read = 1'b1;
        drive_status(3, 2'd1);
        #1 chk("rstalloc_idle", 16'h0000);
        tick();
        #1 chk("rstalloc_miss", 16'h0000);
        tick();
        #1 chk("rstalloc_fill", ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        rst_n = 1'b0; pmem_resp = 1'b1;
        #1 chk("rstalloc_resp_in_reset", ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        rst_n = 1'b1; pmem_resp = 1'b1; mem_read = 1'b0;
        #1 chk("rstalloc_after", 16'h0000);
        tick();
        pmem_resp = 1'b0;
        #1 chk("rstalloc_still_idle", 16'h0000);
        tick();

        // Randomized traffic against the model, with occasional idle gaps.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
                hit = 2'($urandom_range(0, 3));
                pmem_resp = 1'($urandom_range(0, 1));
                #1 chk("idle_gap", 16'h0000);
                tick();
                pmem_resp = 1'b0;
            end
            do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   2'($urandom_range(0, 3)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
